// File: rtl/tft_sync_gen.sv
// tft_sync_gen -- raster timing generator for the TFT-LCD path.
//
// A single horizontal/vertical counter pair advances on CLK edges where the
// pixel enable EN is high. Every output is registered. Each decode is taken
// from the next-count values, so the syncs, DE, X and Y registered on an edge
// describe the H_COUNT/V_COUNT registered on that same edge.
//
// Ports
//   CLK          clock; every register updates on posedge CLK
//   RESET        synchronous active-high reset (wins over EN)
//   EN           pixel enable
//   Hsync/Vsync  sync pulses, at level SYNC_POL while asserted
//   hDE/vDE/DE   horizontal, vertical and combined active windows
//   H_COUNT      pixel position in line (0 = first sync pixel)
//   V_COUNT      line position in frame (0 = first sync line)
//   X/Y          active column/row while in the window, else 0
//   LINE_START   one-CLK pulse on entry to H_COUNT=0
//   FRAME_START  one-CLK pulse on entry to (0,0)
module tft_sync_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter int SYNC_POL = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  output logic       Hsync,
  output logic       Vsync,
  output logic       hDE,
  output logic       vDE,
  output logic       DE,
  output logic [9:0] H_COUNT,
  output logic [9:0] V_COUNT,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       LINE_START,
  output logic       FRAME_START
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("tft_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
      $error("tft_sync_gen: timing parameters must be non-zero");
    end
  endgenerate

  // All boundaries as 10-bit constants so every compare is width-matched.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_DE_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] V_DE_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] H_DE_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_DE_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic       SYNC_ON    = (SYNC_POL != 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nxt;
  logic [9:0] h_nxt, v_nxt, x_nxt, y_nxt;
  logic       hsync_nxt, vsync_nxt, hde_nxt, vde_nxt;
  logic       line_nxt, frame_nxt, run_nxt;

  // Stage: next-count and decode from the current registered counts
  always_comb begin
    state_nxt = state;
    h_nxt     = H_COUNT;
    v_nxt     = V_COUNT;
    line_nxt  = 1'b0;
    frame_nxt = 1'b0;
    if (EN) begin
      if (state == IDLE) begin
        // First enabled edge loads (0,0) itself, so pixel 0 is not skipped.
        state_nxt = RUN;
        h_nxt     = '0;
        v_nxt     = '0;
      end else if (H_COUNT == H_LAST) begin
        h_nxt = '0;
        v_nxt = (V_COUNT == V_LAST) ? 10'd0 : V_COUNT + 10'd1;
      end else begin
        h_nxt = H_COUNT + 10'd1;
      end
      line_nxt  = (h_nxt == 10'd0);
      frame_nxt = (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end

    // While IDLE the decodes are forced to their inactive values; in RUN with
    // EN low the held counts re-decode to the same values, so outputs hold.
    run_nxt   = (state_nxt == RUN);
    hsync_nxt = (run_nxt && h_nxt < H_SYNC_END) ? SYNC_ON : ~SYNC_ON;
    vsync_nxt = (run_nxt && v_nxt < V_SYNC_END) ? SYNC_ON : ~SYNC_ON;
    hde_nxt   = run_nxt && (h_nxt >= H_DE_START) && (h_nxt < H_DE_END);
    vde_nxt   = run_nxt && (v_nxt >= V_DE_START) && (v_nxt < V_DE_END);
    x_nxt     = hde_nxt ? h_nxt - H_DE_START : 10'd0;
    y_nxt     = vde_nxt ? v_nxt - V_DE_START : 10'd0;
  end

  // Stage: output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      H_COUNT     <= '0;
      V_COUNT     <= '0;
      X           <= '0;
      Y           <= '0;
      Hsync       <= ~SYNC_ON;
      Vsync       <= ~SYNC_ON;
      hDE         <= 1'b0;
      vDE         <= 1'b0;
      DE          <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      state       <= state_nxt;
      H_COUNT     <= h_nxt;
      V_COUNT     <= v_nxt;
      X           <= x_nxt;
      Y           <= y_nxt;
      Hsync       <= hsync_nxt;
      Vsync       <= vsync_nxt;
      hDE         <= hde_nxt;
      vDE         <= vde_nxt;
      DE          <= hde_nxt & vde_nxt;
      LINE_START  <= line_nxt;
      FRAME_START <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_tft_sync_gen.sv
// tb_tft_sync_gen -- self-checking bench for tft_sync_gen with a small raster.
// The reference tracks a linear pixel index within the frame and derives
// every expected output from it arithmetically.
module tb_tft_sync_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 5, VFP = 1, VS = 2, VBP = 1;
  localparam int POL = 0;
  localparam int HT = HS + HBP + HA + HFP;   // 15
  localparam int VT = VS + VBP + VA + VFP;   // 9
  localparam int FT = HT * VT;               // 135

  logic       CLK, RESET, EN;
  logic       Hsync, Vsync, hDE, vDE, DE, LINE_START, FRAME_START;
  logic [9:0] H_COUNT, V_COUNT, X, Y;

  tft_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL)
  ) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .Hsync(Hsync), .Vsync(Vsync), .hDE(hDE), .vDE(vDE), .DE(DE),
    .H_COUNT(H_COUNT), .V_COUNT(V_COUNT), .X(X), .Y(Y),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference state
  bit m_run   = 1'b0;
  int m_idx   = 0;
  bit m_pulse = 1'b0;

  // Frame-period / DE-count measurement
  bit meas_on     = 1'b0;
  bit meas_primed = 1'b0;
  int per_exp     = FT;
  int de_exp      = HA * VA;
  int cyc_since   = 0;
  int de_cnt      = 0;

  task automatic step(input logic en, input logic rst);
    int  eh, ev;
    logic son, soff;
    logic e_hde, e_vde;
    EN    = en;
    RESET = rst;
    @(posedge CLK);
    #1;
    if (rst) begin
      m_run = 1'b0; m_idx = 0; m_pulse = 1'b0;
    end else if (en) begin
      if (!m_run) begin
        m_run = 1'b1; m_idx = 0;
      end else begin
        m_idx = (m_idx + 1) % FT;
      end
      m_pulse = 1'b1;
    end else begin
      m_pulse = 1'b0;
    end
    eh    = m_idx % HT;
    ev    = m_idx / HT;
    son   = (POL != 0);
    soff  = ~son;
    e_hde = m_run && eh >= HS + HBP && eh < HS + HBP + HA;
    e_vde = m_run && ev >= VS + VBP && ev < VS + VBP + VA;
    chk("H_COUNT", 32'(H_COUNT), 32'(eh));
    chk("V_COUNT", 32'(V_COUNT), 32'(ev));
    chk("Hsync", 32'(Hsync), 32'((m_run && eh < HS) ? son : soff));
    chk("Vsync", 32'(Vsync), 32'((m_run && ev < VS) ? son : soff));
    chk("hDE", 32'(hDE), 32'(e_hde));
    chk("vDE", 32'(vDE), 32'(e_vde));
    chk("DE", 32'(DE), 32'(e_hde && e_vde));
    chk("X", 32'(X), e_hde ? 32'(eh - (HS + HBP)) : 32'd0);
    chk("Y", 32'(Y), e_vde ? 32'(ev - (VS + VBP)) : 32'd0);
    chk("LINE_START", 32'(LINE_START), 32'(m_pulse && eh == 0));
    chk("FRAME_START", 32'(FRAME_START), 32'(m_pulse && m_idx == 0));

    cyc_since++;
    if (DE) de_cnt++;
    if (FRAME_START) begin
      if (meas_on && meas_primed) begin
        chk("frame_period", 32'(cyc_since), 32'(per_exp));
        chk("de_per_frame", 32'(de_cnt), 32'(de_exp));
      end
      meas_primed = meas_on;
      cyc_since   = 0;
      de_cnt      = 0;
    end
  endtask

  initial begin
    EN    = 1'b0;
    RESET = 1'b1;

    // Reset, then idle with EN low: syncs deasserted, no pulses.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("idle_hsync", 32'(Hsync), 32'd1);
    chk("idle_vsync", 32'(Vsync), 32'd1);
    chk("idle_de", 32'(DE), 32'd0);

    // First enabled edge: (0,0), both syncs asserted, both pulses.
    step(1'b1, 1'b0);
    chk("first_h", 32'(H_COUNT), 32'd0);
    chk("first_fs", 32'(FRAME_START), 32'd1);
    chk("first_ls", 32'(LINE_START), 32'd1);
    chk("first_hsync", 32'(Hsync), 32'd0);
    step(1'b1, 1'b0);
    chk("pulse_clear_fs", 32'(FRAME_START), 32'd0);
    chk("pulse_clear_h", 32'(H_COUNT), 32'd1);

    // EN held high: three frames with period and DE-count checks.
    meas_on = 1'b1; meas_primed = 1'b0;
    per_exp = FT;   de_exp = HA * VA;
    for (int i = 0; i < 3 * FT + 5; i++) step(1'b1, 1'b0);

    // Divide-by-2 enable: everything holds on EN=0 edges.
    meas_primed = 1'b0;
    per_exp = 2 * FT; de_exp = 2 * HA * VA;
    for (int i = 0; i < 3 * FT; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    meas_on = 1'b0;

    // Mid-line reset, then restart from (0,0).
    step(1'b0, 1'b1);
    for (int i = 0; i < 4 * HT + 8; i++) step(1'b1, 1'b0);
    chk("mid_h", 32'(H_COUNT), 32'd7);
    chk("mid_v", 32'(V_COUNT), 32'd4);
    step(1'b1, 1'b1);
    chk("rst_mid_h", 32'(H_COUNT), 32'd0);
    chk("rst_mid_hsync", 32'(Hsync), 32'd1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("restart_fs", 32'(FRAME_START), 32'd1);

    // Corner wrap: run to the last pixel of the frame, next edge is (0,0).
    for (int i = 0; i < FT - 1; i++) step(1'b1, 1'b0);
    chk("corner_h", 32'(H_COUNT), 32'(HT - 1));
    chk("corner_v", 32'(V_COUNT), 32'(VT - 1));
    step(1'b1, 1'b0);
    chk("wrap_fs", 32'(FRAME_START), 32'd1);
    chk("wrap_vsync", 32'(Vsync), 32'd0);

    // Random enable with occasional reset.
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(3) != 0), ($urandom_range(299) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
